// File: rtl/axi4_lite_booth_master.sv
// AXI4-Lite initiator for the Booth multiplier register slave: writes operand A
// and operand B, waits a settle delay, reads back the product.
module axi4_lite_booth_master #(
    parameter int                        Axi_Data_Width     = 32,
    parameter int                        Axi_Addr_Width     = 8,
    parameter logic [Axi_Addr_Width-1:0] Write_to_1_offset  = 8'h08,
    parameter logic [Axi_Addr_Width-1:0] Write_to_2_offset  = 8'h0C,
    parameter logic [Axi_Addr_Width-1:0] read_from_1_offset = 8'h18,
    parameter int                        Settle_cycles      = 4,
    parameter bit                        Hold_arvalid       = 1'b1
) (
    input  logic                          s_axi_clock,
    input  logic                          s_axi_reset,
    input  logic                          start,
    input  logic [Axi_Data_Width-1:0]     operand_a,
    input  logic [Axi_Data_Width-1:0]     operand_b,
    output logic                          busy,
    output logic [Axi_Data_Width-1:0]     result_data,
    output logic                          result_valid,
    output logic                          resp_error,
    output logic [Axi_Addr_Width-1:0]     M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [Axi_Data_Width-1:0]     M_AXI_WDATA,
    output logic [Axi_Data_Width/8-1:0]   M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [Axi_Addr_Width-1:0]     M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [Axi_Data_Width-1:0]     M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int CW = (Settle_cycles > 2) ? $clog2(Settle_cycles) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = (Settle_cycles > 0) ? CW'(Settle_cycles - 1) : '0;

    typedef enum logic [2:0] {IDLE, WR_A, B_A, WR_B, B_B, SETTLE, RD, DONE} state_t;

    state_t                    state_q, state_d;
    logic [Axi_Data_Width-1:0] opb_q;
    logic [CW-1:0]             settle_cnt;
    logic                      aw_done, w_done, b_hs, r_hs;

    // A channel counts as done if its VALID already dropped or it handshakes now.
    assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;
    assign b_hs    = M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    always_ff @(posedge s_axi_clock or negedge s_axi_reset) begin
        if (!s_axi_reset) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = WR_A;
            WR_A:   if (aw_done && w_done) state_d = B_A;
            B_A:    if (b_hs) state_d = WR_B;
            WR_B:   if (aw_done && w_done) state_d = B_B;
            B_B:    if (b_hs) state_d = (Settle_cycles == 0) ? RD : SETTLE;
            SETTLE: if (settle_cnt == '0) state_d = RD;
            RD:     if (r_hs) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_clock or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            opb_q         <= '0;
            settle_cnt    <= '0;
            result_data   <= '0;
            resp_error    <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    opb_q         <= operand_b;
                    resp_error    <= 1'b0;
                    M_AXI_AWADDR  <= Write_to_1_offset;
                    M_AXI_WDATA   <= operand_a;
                    M_AXI_AWVALID <= 1'b1;
                    M_AXI_WVALID  <= 1'b1;
                end
                WR_A, WR_B: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
                    if (aw_done && w_done)              M_AXI_BREADY  <= 1'b1;
                end
                B_A, B_B: if (b_hs) begin
                    M_AXI_BREADY <= 1'b0;
                    if (M_AXI_BRESP != 2'b00) resp_error <= 1'b1;
                    if (state_q == B_A) begin
                        M_AXI_AWADDR  <= Write_to_2_offset;
                        M_AXI_WDATA   <= opb_q;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                    end else if (Settle_cycles == 0) begin
                        M_AXI_ARADDR  <= read_from_1_offset;
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_RREADY  <= 1'b1;
                    end else begin
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        M_AXI_ARADDR  <= read_from_1_offset;
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_RREADY  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RD: begin
                    if (!Hold_arvalid && M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
                    // An early R handshake also retires the address phase.
                    if (r_hs) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b0;
                        result_data   <= M_AXI_RDATA;
                        if (M_AXI_RRESP != 2'b00) resp_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_booth_master.sv
// Scoreboard bench: two masters (settle 4 / hold ARVALID, settle 0 / drop ARVALID)
// each against a small multiplier-register slave model.
module tb_axi4_lite_booth_master;

    localparam int SET  [2] = '{4, 0};
    localparam bit HOLD [2] = '{1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst [2];
    logic        start [2];
    logic [31:0] opa [2], opb [2];
    logic        busy [2], result_valid [2], resp_error [2];
    logic [31:0] result_data [2];
    logic [7:0]  awaddr [2], araddr [2];
    logic [2:0]  awprot [2], arprot [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2];
    logic [31:0] wdata [2], rdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];
    logic        bvalid [2], bready [2], arvalid [2], arready [2], rvalid [2], rready [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi4_lite_booth_master #(.Settle_cycles(SET[g]), .Hold_arvalid(HOLD[g])) u_dut (
            .s_axi_clock(clk), .s_axi_reset(rst[g]), .start(start[g]),
            .operand_a(opa[g]), .operand_b(opb[g]), .busy(busy[g]),
            .result_data(result_data[g]), .result_valid(result_valid[g]), .resp_error(resp_error[g]),
            .M_AXI_AWADDR(awaddr[g]), .M_AXI_AWPROT(awprot[g]), .M_AXI_AWVALID(awvalid[g]),
            .M_AXI_AWREADY(awready[g]), .M_AXI_WDATA(wdata[g]), .M_AXI_WSTRB(wstrb[g]),
            .M_AXI_WVALID(wvalid[g]), .M_AXI_WREADY(wready[g]), .M_AXI_BRESP(bresp[g]),
            .M_AXI_BVALID(bvalid[g]), .M_AXI_BREADY(bready[g]), .M_AXI_ARADDR(araddr[g]),
            .M_AXI_ARPROT(arprot[g]), .M_AXI_ARVALID(arvalid[g]), .M_AXI_ARREADY(arready[g]),
            .M_AXI_RDATA(rdata[g]), .M_AXI_RRESP(rresp[g]), .M_AXI_RVALID(rvalid[g]),
            .M_AXI_RREADY(rready[g]));
    end

    // ---------------- slave model ----------------
    int          cfg_wdly [2];
    logic        cfg_berr [2];
    logic        aw_got [2], w_got [2], ar_got [2];
    logic [7:0]  s_addr [2];
    logic [31:0] s_data [2], reg_a [2], reg_b [2];
    int          wwait [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                awready[i] <= 1'b0; wready[i] <= 1'b0; bvalid[i] <= 1'b0; bresp[i] <= 2'b00;
                arready[i] <= 1'b0; rvalid[i] <= 1'b0; rresp[i] <= 2'b00; rdata[i] <= '0;
                aw_got[i] <= 1'b0; w_got[i] <= 1'b0; ar_got[i] <= 1'b0; wwait[i] <= 0;
                s_addr[i] <= '0; s_data[i] <= '0; reg_a[i] <= '0; reg_b[i] <= '0;
            end else begin
                awready[i] <= awvalid[i] && !awready[i] && !aw_got[i];
                if (awvalid[i] && awready[i]) begin aw_got[i] <= 1'b1; s_addr[i] <= awaddr[i]; end
                if (wvalid[i] && !w_got[i]) wwait[i] <= wwait[i] + 1;
                wready[i] <= wvalid[i] && !wready[i] && !w_got[i] && (wwait[i] >= cfg_wdly[i]);
                if (wvalid[i] && wready[i]) begin w_got[i] <= 1'b1; s_data[i] <= wdata[i]; end
                if (aw_got[i] && w_got[i] && !bvalid[i]) begin
                    bvalid[i] <= 1'b1;
                    bresp[i]  <= (cfg_berr[i] && s_addr[i] == 8'h0C) ? 2'b10 : 2'b00;
                    if (s_addr[i] == 8'h08) reg_a[i] <= s_data[i];
                    else                    reg_b[i] <= s_data[i];
                    aw_got[i] <= 1'b0; w_got[i] <= 1'b0; wwait[i] <= 0;
                end
                if (bvalid[i] && bready[i]) bvalid[i] <= 1'b0;
                arready[i] <= arvalid[i] && !arready[i] && !ar_got[i];
                if (arvalid[i] && arready[i]) ar_got[i] <= 1'b1;
                // The held-ARVALID instance's slave only answers if ARVALID is still up.
                if (ar_got[i] && !rvalid[i] && (!HOLD[i] || arvalid[i])) begin
                    rvalid[i] <= 1'b1; rdata[i] <= reg_a[i] * reg_b[i]; rresp[i] <= 2'b00;
                end
                if (rvalid[i] && rready[i]) begin rvalid[i] <= 1'b0; ar_got[i] <= 1'b0; end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_aw [2][$];
    logic [31:0] exp_w  [2][$];
    logic [32:0] exp_res [2][$];
    int n_cmp = 0, n_bad = 0;
    logic fin = 1'b0;

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, i, act, exp);
        end
    endtask

    initial begin : monitor
        int  bcnt [2], arcnt [2], gap [2], bcyc [2];
        bit  gap_on [2], ar_next [2], r_next [2], rv_prev [2], acc_prev [2], rst_seen [2];
        bit  fin_done;
        logic [32:0] e;
        fin_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bcnt[i] = 0; arcnt[i] = 0; gap[i] = 0; bcyc[i] = 0; gap_on[i] = 0; ar_next[i] = 0;
            r_next[i] = 0; rv_prev[i] = 0; acc_prev[i] = 0; rst_seen[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst[i]) begin
                    if (!rst_seen[i]) begin
                        chk("reset_outputs", i, {awvalid[i], wvalid[i], bready[i], arvalid[i], rready[i],
                            busy[i], result_valid[i], resp_error[i]}, 0);
                        chk("reset_result_data", i, result_data[i], 0);
                        rst_seen[i] = 1;
                    end
                    exp_aw[i].delete(); exp_w[i].delete(); exp_res[i].delete();
                    bcnt[i] = 0; arcnt[i] = 0; bcyc[i] = 0; gap_on[i] = 0; ar_next[i] = 0;
                    r_next[i] = 0; rv_prev[i] = 0; acc_prev[i] = 0;
                end else begin
                    rst_seen[i] = 0;
                    bcyc[i] = busy[i] ? bcyc[i] + 1 : 0;
                    if (bcyc[i] == 400) begin
                        n_cmp++; n_bad++;
                        $display("FAIL busy_timeout dut%0d: busy still 1 after 400 cycles, expected completion", i);
                    end
                    if (acc_prev[i]) chk("start_accept_busy_err", i, {busy[i], resp_error[i]}, 2'b10);
                    acc_prev[i] = start[i] && !busy[i];
                    if (ar_next[i]) chk("arvalid_after_ar_hs", i, arvalid[i], HOLD[i]);
                    ar_next[i] = 0;
                    if (r_next[i]) chk("ar_r_drop_after_r_hs", i, {arvalid[i], rready[i]}, 0);
                    r_next[i] = 0;
                    if (gap_on[i]) begin
                        gap[i]++;
                        if (arvalid[i]) begin chk("settle_gap", i, gap[i], SET[i] + 1); gap_on[i] = 0; end
                    end
                    if (awvalid[i] && awready[i]) begin
                        chk("aw_expected", i, exp_aw[i].size() != 0, 1);
                        if (exp_aw[i].size() != 0) chk("aw_addr", i, awaddr[i], exp_aw[i].pop_front());
                        chk("prot_strb", i, {awprot[i], arprot[i], wstrb[i]}, {3'b0, 3'b0, 4'hF});
                    end
                    if (wvalid[i] && wready[i]) begin
                        chk("w_expected", i, exp_w[i].size() != 0, 1);
                        if (exp_w[i].size() != 0) chk("w_data", i, wdata[i], exp_w[i].pop_front());
                        if (cfg_wdly[i] > 0) chk("awvalid_dropped_alone", i, awvalid[i], 0);
                    end
                    if (bvalid[i] && bready[i]) begin
                        bcnt[i]++;
                        if (bcnt[i] == 2) begin gap[i] = 0; gap_on[i] = 1; end
                    end
                    if (arvalid[i] && arready[i]) begin
                        arcnt[i]++; ar_next[i] = !(rvalid[i] && rready[i]);
                        chk("ar_addr", i, araddr[i], 8'h18);
                    end
                    if (rvalid[i] && rready[i]) r_next[i] = 1;
                    if (rv_prev[i]) chk("result_valid_pulse", i, result_valid[i], 0);
                    rv_prev[i] = result_valid[i];
                    if (result_valid[i]) begin
                        chk("result_expected", i, exp_res[i].size() != 0, 1);
                        if (exp_res[i].size() != 0) begin
                            e = exp_res[i].pop_front();
                            chk("result_data", i, result_data[i], e[31:0]);
                            chk("resp_error", i, resp_error[i], e[32]);
                        end
                        chk("txn_counts_b_ar_busy", i, {bcnt[i][7:0], arcnt[i][7:0], busy[i]}, {8'd2, 8'd1, 1'b1});
                        bcnt[i] = 0; arcnt[i] = 0;
                    end
                end
            end
            if (fin && !fin_done) begin
                for (int i = 0; i < 2; i++)
                    chk("queues_drained", i, {exp_aw[i].size(), exp_w[i].size(), exp_res[i].size()}, 0);
                fin_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic err);
        exp_aw[i].push_back(8'h08); exp_aw[i].push_back(8'h0C);
        exp_w[i].push_back(a);      exp_w[i].push_back(b);
        exp_res[i].push_back({err, p});
        opa[i] = a; opb[i] = b;
    endtask

    task automatic wait_result(input int i);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (result_valid[i]) break;
        end
    endtask

    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic err);
        push_op(i, a, b, p, err);
        pulse_start(i);
        wait_result(i);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; opa[i] = '0; opb[i] = '0; cfg_wdly[i] = 0; cfg_berr[i] = 1'b0;
        end
        #2;
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (2) @(posedge clk);

        // instance 0: settle 4, ARVALID held until R
        run_op(0, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 1'b0);
        cfg_wdly[0] = 4;
        run_op(0, 32'd7, 32'd6, 32'h0000_002A, 1'b0);
        cfg_wdly[0] = 0;
        cfg_berr[0] = 1'b1;
        run_op(0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
        cfg_berr[0] = 1'b0;
        run_op(0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);

        // instance 1: settle 0, ARVALID dropped at AR handshake; start held through an op
        push_op(1, 32'd5, 32'd9, 32'h0000_002D, 1'b0);
        @(posedge clk); #1 start[1] = 1'b1;
        wait_result(1);
        start[1] = 1'b0;
        repeat (4) @(posedge clk);

        // reset while the operand B write is in flight
        cfg_wdly[1] = 10;
        push_op(1, 32'hAAAA_0000, 32'h0000_5555, 32'h0, 1'b0);
        pulse_start(1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (awvalid[1] && awaddr[1] == 8'h0C) break;
        end
        @(posedge clk); #1 rst[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst[1] = 1'b1;
        cfg_wdly[1] = 0;
        repeat (2) @(posedge clk);
        run_op(1, 32'h1234_5678, 32'd2, 32'h2468_ACF0, 1'b0);

        fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
